// File: rtl/ioddr_phy_pkg.sv
// rtl/ioddr_phy_pkg.sv - shared state type and width helpers for the DDR I/O PHY
package ioddr_phy_pkg;

  typedef enum logic [1:0] {IDLE, TX, TURN, RX} state_t;

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pointer carries one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int lat_width(input int lat_max);
    return (lat_max > 1) ? clog2(lat_max) : 1;
  endfunction

endpackage

// File: rtl/ioddr_rx_fifo.sv
// rtl/ioddr_rx_fifo.sv - first-word-fall-through capture FIFO for the DDR I/O PHY
module ioddr_rx_fifo
  import ioddr_phy_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int PW = ptr_width(DEPTH),
  localparam int AW = PW - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign valid = !empty;
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ioddr_phy.sv
// rtl/ioddr_phy.sv - handshaked DDR pad datapath: write drive, turnaround, aligned read capture
module ioddr_phy
  import ioddr_phy_pkg::*;
#(
  parameter string TARGET      = "GENERIC",
  parameter int    WIDTH       = 8,
  parameter int    RD_LAT_MAX  = 4,
  parameter int    TURN_CYCLES = 2,
  parameter int    FIFO_DEPTH  = 8,
  localparam int   LW          = lat_width(RD_LAT_MAX)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LW-1:0]      cfg_rd_lat,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [2*WIDTH-1:0] tx_data,
  input  logic [1:0]         tx_mask,
  input  logic               rx_en,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [2*WIDTH-1:0] rx_data,
  output logic               rx_ovf,
  input  logic               rx_ovf_clr,
  output logic               busy,
  inout  wire  [WIDTH-1:0]   dq,
  inout  wire                rwds
);

  localparam int CW = (TURN_CYCLES > 1) ? clog2(TURN_CYCLES) : 1;
  localparam int DL = RD_LAT_MAX - 1;

  state_t        state;
  logic [CW-1:0] turn_cnt;
  logic          tx_take;
  logic          rx_take;

  assign tx_take = tx_valid && tx_ready;
  // rx_en is honoured on the IDLE cycle that enters RX as well as inside RX.
  assign rx_take = rx_en && (((state == IDLE) && !tx_valid) || (state == RX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      turn_cnt <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state <= TX;
            busy  <= 1'b1;
          end else if (rx_en) begin
            state    <= RX;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        TX: begin
          if (!tx_valid) begin
            state    <= TURN;
            turn_cnt <= CW'(TURN_CYCLES - 1);
            tx_ready <= 1'b0;
          end
        end
        TURN: begin
          if (turn_cnt == '0) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt - CW'(1);
          end
        end
        RX: begin
          if (!rx_en) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic               oe;
  logic [2*WIDTH-1:0] tx_word;
  logic [1:0]         tx_mask_q;
  logic [WIDTH-1:0]   dq_out;
  logic               rwds_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe        <= 1'b0;
      tx_word   <= '0;
      tx_mask_q <= '0;
    end else begin
      oe <= tx_take;
      if (tx_take) begin
        tx_word   <= tx_data;
        tx_mask_q <= tx_mask;
      end
    end
  end

  if (TARGET == "ALTERA") begin : g_altera
    // Second phase retimed on the falling edge, as the vendor output cell does.
    logic [WIDTH-1:0] lo_q;
    logic             mask_lo_q;
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lo_q      <= '0;
        mask_lo_q <= 1'b0;
      end else begin
        lo_q      <= tx_word[2*WIDTH-1:WIDTH];
        mask_lo_q <= tx_mask_q[1];
      end
    end
    assign dq_out   = clk ? tx_word[WIDTH-1:0] : lo_q;
    assign rwds_out = clk ? tx_mask_q[0] : mask_lo_q;
  end else begin : g_generic
    assign dq_out   = clk ? tx_word[WIDTH-1:0] : tx_word[2*WIDTH-1:WIDTH];
    assign rwds_out = clk ? tx_mask_q[0] : tx_mask_q[1];
  end

  assign dq   = oe ? dq_out : {WIDTH{1'bz}};
  assign rwds = oe ? rwds_out : 1'bz;

  logic [WIDTH-1:0]   cap_hi;
  logic [WIDTH-1:0]   cap_lo;
  logic               cap_valid;
  logic [2*WIDTH-1:0] dl_word [DL];
  logic [DL-1:0]      dl_valid;
  logic               push_valid;
  logic [2*WIDTH-1:0] push_word;
  logic               drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_hi    <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_hi    <= dq;
      cap_valid <= rx_take;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) cap_lo <= '0;
    else        cap_lo <= dq;
  end

  // Capture register is stage 0 of the alignment line; dl_* hold stages 1..RD_LAT_MAX-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid <= '0;
      for (int k = 0; k < DL; k++) dl_word[k] <= '0;
    end else begin
      dl_valid[0] <= cap_valid;
      dl_word[0]  <= {cap_hi, cap_lo};
      for (int k = 1; k < DL; k++) begin
        dl_valid[k] <= dl_valid[k-1];
        dl_word[k]  <= dl_word[k-1];
      end
    end
  end

  always_comb begin
    push_valid = cap_valid;
    push_word  = {cap_hi, cap_lo};
    if (cfg_rd_lat != '0) begin
      push_valid = dl_valid[cfg_rd_lat - LW'(1)];
      push_word  = dl_word[cfg_rd_lat - LW'(1)];
    end
  end

  ioddr_rx_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_valid),
    .push_data (push_word),
    .pop       (rx_ready),
    .valid     (rx_valid),
    .head      (rx_data),
    .drop      (drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rx_ovf <= 1'b0;
    else if (drop)       rx_ovf <= 1'b1;
    else if (rx_ovf_clr) rx_ovf <= 1'b0;
  end

endmodule

// File: doc/ioddr_phy.md
# ioddr_phy

Parametrised DDR I/O PHY for the HyperBus controller, replacing the bare tristate DDR cell with a handshaked datapath. Drives the DQ bus and RWDS (as write mask) on both clock edges, enforces bus turnaround, and captures read data with a programmable alignment delay. Captured data goes into a first-word-fall-through FIFO. Sits between the HyperBus transaction FSM and the pads.

## Interface
- TARGET, "GENERIC": "GENERIC" (edge-modelled RTL) or "ALTERA" (vendor DDR cells; same cycle behaviour)
- WIDTH, 8: DQ lanes
- RD_LAT_MAX, 4: alignment delay stages; cfg_rd_lat range 0..RD_LAT_MAX-1
- TURN_CYCLES, 2: idle cycles (oe=0) after last write word, ≥1
- FIFO_DEPTH, 8: read FIFO entries, power of two
- clk  in  1  single clock; both edges used in pad logic
- rst_n  in  1  asynchronous, active-low reset
- cfg_rd_lat  in  clog2(RD_LAT_MAX)  read alignment delay in cycles; static while busy=1
- tx_valid  in  1  write word offered
- tx_ready  out  1  write word accepted when tx_valid&tx_ready
- tx_data  in  2*WIDTH  [WIDTH-1:0] first (high clk phase), [2W-1:W] second (low phase)
- tx_mask  in  2  RWDS value per phase: [0] first, [1] second
- rx_en  in  1  read capture window
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  pop when rx_valid&rx_ready
- rx_data  out  2*WIDTH  FIFO head; [2W-1:W] sampled at rising edge, [W-1:0] at following falling edge
- rx_ovf  out  1  sticky overflow flag
- rx_ovf_clr  in  1  clears rx_ovf
- busy  out  1  state ≠ IDLE
- dq  inout  WIDTH  pad data
- rwds  inout  1  pad strobe/mask; driven only while oe=1

## Operation
- States: IDLE, TX, TURN, RX. oe=1 only in TX.
- IDLE: tx_valid → TX (word accepted this cycle); else rx_en → RX. Both asserted: TX wins.
- TX: tx_ready=1; each accepted word driven next cycle. Cycle with tx_valid=0 → TURN, counter loaded TURN_CYCLES-1.
- TURN: tx_ready=0, rx_en ignored; counter reaches 0 → IDLE.
- RX: tx_ready=0, tx_valid ignored; each cycle with rx_en=1 produces one captured word tagged valid; rx_en=0 → IDLE.
- Alignment: tagged word delayed exactly cfg_rd_lat cycles through a RD_LAT_MAX-deep shift register before FIFO push; words in flight still push after leaving RX.
- FIFO: FWFT. Push when full and no pop: word dropped, rx_ovf set. Push+pop same cycle when full: both occur, no overflow. Pop when empty ignored.
- rx_ovf_clr and new overflow same cycle: rx_ovf stays 1.
- Reset mid-transfer: immediate return to IDLE, pads released, FIFO and delay line emptied.

## Timing
- Reset values: tx_ready=1 once released (state IDLE), rx_valid=0, rx_data=0, rx_ovf=0, busy=0, oe=0, dq/rwds=Z.
- Write latency: word accepted at edge N → tx_data[W-1:0]/tx_mask[0] on pads for high phase of cycle N+1, tx_data[2W-1:W]/tx_mask[1] for low phase.
- oe asserts with first driven phase, deasserts at rising edge after last driven low phase.
- Back-to-back writes: one word per cycle, no bubble.
- Read latency: rx_en=1 in cycle N → word visible on rx_data (rx_valid=1) at cycle N+2+cfg_rd_lat when FIFO empty.
- Turnaround: earliest RX entry is TURN_CYCLES+1 cycles after last TX cycle.

## Structure
- Package ioddr_phy_pkg: state enum (IDLE, TX, TURN, RX), clog2 helper, derived widths for FIFO pointers and cfg_rd_lat.
- Sub-module ioddr_rx_fifo: synchronous FWFT FIFO, WIDTH=2*WIDTH, DEPTH=FIFO_DEPTH, full/empty via extra pointer bit.
- Pad cell selection by TARGET generate inside ioddr_phy.

## Test plan
- Write burst: 3 words 0xA55A, 0x1234, 0xFFFF, mask 2'b01 → dq shows 5A,A5,34,12,FF,FF on successive phases starting cycle after accept; rwds 1,0 each word; oe low TURN_CYCLES cycles after.
- Read, cfg_rd_lat=2: dq driven by bench 0x11/0x22 per phase, rx_en 1 cycle at N → rx_data=0x1122, rx_valid at N+4.
- Overflow: FIFO_DEPTH=8, rx_ready=0, 9 read cycles → 8 entries kept, rx_ovf=1; 9th word absent; rx_ovf_clr → 0.
- Full with simultaneous pop: full FIFO, rx_ready=1 during 1 capture → no overflow, count stays 8.
- Arbitration: tx_valid and rx_en asserted together in IDLE → TX entered; rx_en ignored until TURN done.
- Async reset during TX burst → dq/rwds Z immediately, busy=0, rx_valid=0, tx_ready=1 after release.
